// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider controller for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write path and stalls F/D/E
// while a divide is in flight.
// Optional build macro: DIV_EARLY_OUT_EN (finish in one cycle when |a| < |b|).
//
// state | meaning
// IDLE  | waiting for an accepted start
// BUSY  | one restoring step per cycle, WIDTH steps
// DONE  | result valid, ready pulses for one cycle
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg;
  logic [CW-1:0]    cnt;

  logic             a_neg, b_neg, b_zero, early, accept, last, borrow;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quo_nxt, q_fix, r_fix;
  logic [WIDTH:0]   rem_sh, diff;

  // Operand magnitudes and request qualification in IDLE
  always_comb begin
    a_neg  = signed_div & a[WIDTH-1];
    b_neg  = signed_div & b[WIDTH-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
    b_zero = (b == '0);
    accept = (state == IDLE) & start & ~annul;
    early  = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    // Quotient is zero and remainder is the original dividend
    early  = ~b_zero & (a_mag < b_mag);
`endif
  end

  // One restoring step plus the sign fixup applied on the final step
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs};
    // rem < dvs always holds, so the shifted value stays below 2*dvs and
    // the top bit of the difference is a reliable borrow flag
    borrow  = diff[WIDTH];
    rem_nxt = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~borrow};
    q_fix   = q_neg ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fix   = r_neg ? (~rem_nxt + 1'b1) : rem_nxt;
    last    = (state == BUSY) & (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; annul overrides everything but reset
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (b_zero | early) ? DONE : BUSY;
      BUSY: if (last)   state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (annul) begin
      state_nxt = IDLE;
      ready     = 1'b0;
    end
    stall = start & ~ready;
  end

  // Datapath: latch operands on accept, iterate in BUSY, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      rem   <= '0;
      quo   <= a_mag;
      dvs   <= b_mag;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      cnt   <= '0;
      if (b_zero)     result <= {a, {WIDTH{1'b1}}};
      else if (early) result <= {a, {WIDTH{1'b0}}};
    end else if ((state == BUSY) && !annul) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 1'b1;
      if (last) result <= {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_sequencer;

  logic        clk, rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        stall, ready;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;
  int early_lat;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .stall(stall), .ready(ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is on a falling edge with the DUT in IDLE; this is cycle 0.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input int exp_lat, input logic [63:0] exp_res,
                        input bit keep);
    int got;
    got = -1;
    a = av; b = bv; signed_div = sg; start = 1'b1;
    #1;
    chk({tag, " stall_c0"}, 64'(stall), 64'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = c;
        break;
      end
      chk({tag, " stall_busy"}, 64'(stall), 64'd1);
    end
    chk({tag, " latency"}, 64'(got), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " stall_at_ready"}, 64'(stall), 64'd0);
    if (!keep) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div("udiv 100/7", 32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b0);
    @(negedge clk);
    do_div("sdiv -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    @(negedge clk);
    do_div("udiv fff9/2", 32'hFFFFFFF9, 32'd2, 1'b0, 33, {32'd1, 32'h7FFFFFFC}, 1'b0);
    @(negedge clk);
    do_div("sdiv 7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 33, {32'd1, 32'hFFFFFFFD}, 1'b0);
    @(negedge clk);
    do_div("sdiv min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, {32'd0, 32'h80000000}, 1'b0);
    @(negedge clk);
    do_div("udiv max/1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFFFFFF}, 1'b0);
    @(negedge clk);
    do_div("div by zero", 32'h12345678, 32'd0, 1'b0, 1, {32'h12345678, 32'hFFFFFFFF}, 1'b0);
    @(negedge clk);

    // Annul in cycle 10 of a divide
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("annul pre ready", 64'(ready), 64'd0);
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul c10 ready", 64'(ready), 64'd0);
    chk("annul c10 result", result, {32'h12345678, 32'hFFFFFFFF});
    @(negedge clk);
    annul = 1'b0;
    chk("annul c11 ready", 64'(ready), 64'd0);
    chk("annul c11 result", result, {32'h12345678, 32'hFFFFFFFF});
    do_div("after annul 9/3", 32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, 1'b0);
    @(negedge clk);

    // Reset in cycle 15 of a divide
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int c = 1; c <= 14; c++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("midreset ready", 64'(ready), 64'd0);
    chk("midreset result", result, 64'd0);
    chk("midreset stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postreset ready", 64'(ready), 64'd0);
    do_div("after reset 20/6", 32'd20, 32'd6, 1'b0, 33, {32'd2, 32'd3}, 1'b0);
    @(negedge clk);

    // Back-to-back: start stays high right after the first ready
    do_div("b2b 50/5", 32'd50, 32'd5, 1'b0, 33, {32'd0, 32'd10}, 1'b1);
    a = 32'd60; b = 32'd4;
    @(negedge clk);
    chk("b2b idle ready", 64'(ready), 64'd0);
    do_div("b2b 60/4", 32'd60, 32'd4, 1'b0, 33, {32'd0, 32'd15}, 1'b0);
    @(negedge clk);

`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 33;
`endif
    do_div("small 3/8", 32'd3, 32'd8, 1'b0, early_lat, {32'd3, 32'd0}, 1'b0);
    @(negedge clk);
    do_div("small -3/8", 32'hFFFFFFFD, 32'd8, 1'b1, early_lat, {32'hFFFFFFFD, 32'd0}, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
